// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the stall-state encoding, register-index width and flush bit indices.
package hazard_pkg;

   localparam int REG_W    = 5;

   localparam int FL_IFID  = 0;
   localparam int FL_IDEX  = 1;
   localparam int FL_EXMEM = 2;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_XSTALL  = 2'd2,
      ST_CSTALL  = 2'd3
   } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/EX hazard inputs, pipeline write enables,
// flush/bubble controls and status. master = pipeline side, slave = controller.
// Optional perf counters (stall_cnt, flush_cnt) exist with HAZARD_PERF_EN.
interface hazard_ctrl_if
   import hazard_pkg::*;
#(
   parameter int NUM_SRC     = 2,
   parameter int FLUSH_DEPTH = 2
);

   logic [NUM_SRC*REG_W-1:0] rs_d;
   logic [NUM_SRC-1:0]       rs_used_d;
   logic [REG_W-1:0]         rd_e;
   logic                     mem_read_e;
   logic                     branch_e;
   logic                     jump_e;
   logic                     jalr_e;
   logic                     cond_true_e;
   logic                     ex_busy;
   logic                     cache_stall;

   logic                     pc_we;
   logic                     if_id_we;
   logic                     id_ex_we;
   logic                     ex_mem_we;
   logic [FLUSH_DEPTH-1:0]   flush;
   logic                     bubble_ex;
   logic                     bubble_mem;
   logic                     redirect_e;
   logic [1:0]               state;
   logic                     wdog_err;
`ifdef HAZARD_PERF_EN
   logic [31:0]              stall_cnt;
   logic [31:0]              flush_cnt;
`endif

   modport master (
      output rs_d, rs_used_d, rd_e, mem_read_e,
      output branch_e, jump_e, jalr_e, cond_true_e,
      output ex_busy, cache_stall,
      input  pc_we, if_id_we, id_ex_we, ex_mem_we,
      input  flush, bubble_ex, bubble_mem,
      input  redirect_e, state, wdog_err
`ifdef HAZARD_PERF_EN
      , input stall_cnt, flush_cnt
`endif
   );

   modport slave (
      input  rs_d, rs_used_d, rd_e, mem_read_e,
      input  branch_e, jump_e, jalr_e, cond_true_e,
      input  ex_busy, cache_stall,
      output pc_we, if_id_we, id_ex_we, ex_mem_we,
      output flush, bubble_ex, bubble_mem,
      output redirect_e, state, wdog_err
`ifdef HAZARD_PERF_EN
      , output stall_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// load_scoreboard: shift register of in-flight loads past EX (valid, rd).
// Ports: shift_en_i/ins_* load the youngest slot; rs_i/rs_used_i -> hit_o.
module load_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int NSLOT   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     shift_en_i,
   input  logic                     ins_vld_i,
   input  logic [REG_W-1:0]         ins_rd_i,
   input  logic [NUM_SRC*REG_W-1:0] rs_i,
   input  logic [NUM_SRC-1:0]       rs_used_i,
   output logic                     hit_o
);

   if (NSLOT == 0) begin : g_none
      // Load data forwards straight out of MEM; nothing to track.
      logic unused_sb;
      assign unused_sb = ^{clk, rst_n, shift_en_i, ins_vld_i,
                           ins_rd_i, rs_i, rs_used_i};
      assign hit_o = 1'b0;
   end else begin : g_slots
      logic [NSLOT-1:0]            vld_d, vld_q;
      logic [NSLOT-1:0][REG_W-1:0] rd_d, rd_q;

      always_comb begin
         vld_d = vld_q;
         rd_d  = rd_q;
         if (shift_en_i) begin
            vld_d[0] = ins_vld_i;
            rd_d[0]  = ins_rd_i;
            for (int s = 1; s < NSLOT; s++) begin
               vld_d[s] = vld_q[s-1];
               rd_d[s]  = rd_q[s-1];
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= '0;
            rd_q  <= '0;
         end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
         end
      end

      always_comb begin
         hit_o = 1'b0;
         for (int s = 0; s < NSLOT; s++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (vld_q[s] && rs_used_i[i] &&
                   rs_i[i*REG_W +: REG_W] != '0 &&
                   rs_i[i*REG_W +: REG_W] == rd_q[s])
                  hit_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/bubble control with load
// scoreboard, cache-stall watchdog and 2-bit cause register.
// Ports: clk, rst_n (async, active low), hz (hazard_ctrl_if.slave).
// Optional: HAZARD_PERF_EN adds stall_cnt / flush_cnt counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NUM_SRC     = 2,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 2,
   parameter int WDOG_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   hazard_ctrl_if.slave hz
);

   localparam int NSLOT = LOAD_LAT - 1;
   localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
   localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(WDOG_CYCLES);
   localparam logic [2:0] FL_ALL = (3'b1 << FL_IFID)
                                 | (3'b1 << FL_IDEX)
                                 | (3'b1 << FL_EXMEM);

   logic       redirect, ex_hit, sb_hit, ld_use, sb_ins;
   logic       pc_we, if_id_we, id_ex_we, ex_mem_we;
   logic       bub_ex, bub_mem;
   logic [FLUSH_DEPTH-1:0] flush;
   state_e     state_d, state_q;
   logic [CNT_W-1:0] wcnt_d, wcnt_q;
   logic       wdog_d, wdog_q;

   assign redirect = (hz.branch_e & hz.cond_true_e)
                   | hz.jump_e | hz.jalr_e;

   // Loads held by a busy EX unit are re-presented later; only a
   // completing load with a real destination enters the scoreboard.
   assign sb_ins = hz.mem_read_e & ~hz.ex_busy & (hz.rd_e != '0);

   always_comb begin
      ex_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hz.mem_read_e && hz.rs_used_d[i] &&
             hz.rs_d[i*REG_W +: REG_W] != '0 &&
             hz.rs_d[i*REG_W +: REG_W] == hz.rd_e)
            ex_hit = 1'b1;
      end
   end

   load_scoreboard #(
      .NUM_SRC (NUM_SRC),
      .NSLOT   (NSLOT)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en_i (~hz.cache_stall),
      .ins_vld_i  (sb_ins),
      .ins_rd_i   (hz.rd_e),
      .rs_i       (hz.rs_d),
      .rs_used_i  (hz.rs_used_d),
      .hit_o      (sb_hit)
   );

   assign ld_use = ex_hit | sb_hit;

   always_comb begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      flush     = '0;
      bub_ex    = 1'b0;
      bub_mem   = 1'b0;
      state_d   = ST_RUN;
      if (hz.cache_stall) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         state_d   = ST_CSTALL;
      end else if (hz.ex_busy) begin
         pc_we    = 1'b0;
         if_id_we = 1'b0;
         id_ex_we = 1'b0;
         bub_mem  = 1'b1;
         state_d  = ST_XSTALL;
      end else if (redirect) begin
         // The stalled consumer is on the wrong path; flushing wins.
         flush = FL_ALL[FLUSH_DEPTH-1:0];
      end else if (ld_use) begin
         pc_we    = 1'b0;
         if_id_we = 1'b0;
         bub_ex   = 1'b1;
         state_d  = ST_LDSTALL;
      end
   end

   always_comb begin
      if (!hz.cache_stall)
         wcnt_d = '0;
      else if (wcnt_q == WDOG_MAX)
         wcnt_d = wcnt_q;
      else
         wcnt_d = wcnt_q + 1'b1;
      wdog_d = wdog_q | (wcnt_d == WDOG_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         wcnt_q  <= '0;
         wdog_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         wdog_q  <= wdog_d;
      end
   end

   assign hz.pc_we      = pc_we;
   assign hz.if_id_we   = if_id_we;
   assign hz.id_ex_we   = id_ex_we;
   assign hz.ex_mem_we  = ex_mem_we;
   assign hz.flush      = flush;
   assign hz.bubble_ex  = bub_ex;
   assign hz.bubble_mem = bub_mem;
   assign hz.redirect_e = redirect;
   assign hz.state      = state_q;
   assign hz.wdog_err   = wdog_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_d, stall_cnt_q;
   logic [31:0] flush_cnt_d, flush_cnt_q;

   assign stall_cnt_d = stall_cnt_q + {31'd0, ~pc_we};
   assign flush_cnt_d = flush_cnt_q + {31'd0, redirect};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule
